// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM control signals of the SRAM port arbiter.
// The arbiter uses the slave modport. The requesters and the SRAM device
// together use the master modport. The bidirectional SRAM data bus is a
// plain port on the arbiter so the pad tristate stays at module level.
interface sram_port_arbiter_if;
    // Instruction-fetch port
    logic        inst_req_i;
    logic [19:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_stall_o;

    // Data port
    logic [3:0]  data_op_i;
    logic [19:0] data_addr_i;
    logic [1:0]  data_bytes_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;

    // SRAM control
    logic [19:0] sram_addr_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    // Status
    logic        busy_o;

    modport slave (
        input  inst_req_i, inst_addr_i,
        output inst_rdata_o, inst_stall_o,
        input  data_op_i, data_addr_i, data_bytes_i, data_wdata_i,
        output data_rdata_o, data_stall_o,
        output sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
        output busy_o
    );

    modport master (
        output inst_req_i, inst_addr_i,
        input  inst_rdata_o, inst_stall_o,
        output data_op_i, data_addr_i, data_bytes_i, data_wdata_i,
        input  data_rdata_o, data_stall_o,
        input  sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
        input  busy_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// SRAM port arbiter: shares one word-addressed asynchronous SRAM between
// the instruction-fetch port and the data port. Data accesses always win.
// The arbiter sequences the SRAM strobes, byte enables and bus tristate,
// and it stalls each requester until its access is acknowledged.
//
// Data op encoding (MEM_*):
//   0 NOP, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 SW, 7 SH, 8 SB.
//   Any other code is treated as no request.
module sram_port_arbiter #(
    parameter int READ_CYCLES  = 1,
    parameter int WRITE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_port_arbiter_if.slave        bus,
    inout  wire  [31:0]               sram_data_io
);

    // Data-port op codes
    localparam logic [3:0] MEM_LW  = 4'd1;
    localparam logic [3:0] MEM_LB  = 4'd2;
    localparam logic [3:0] MEM_LBU = 4'd3;
    localparam logic [3:0] MEM_LH  = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SW  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;

    // Sequencer states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_ACK      = 3'd5;

    // Owner encoding of the access currently in flight
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // One counter serves both the read and the write-pulse phases
    localparam int MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic [19:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be_n;
    logic [31:0]      r_inst_rdata;
    logic [31:0]      r_data_rdata;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_data_req;
    logic [3:0]       w_store_be_n;
    logic             w_rd_done;
    logic             w_ce_n;
    logic             w_oe_n;
    logic             w_we_n;
    logic [3:0]       w_be_n;
    logic             w_drive_en;

    // Classify the data-port op into load / store / no request
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (bus.data_op_i)
            MEM_LW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU: w_is_load  = 1'b1;
            MEM_SW, MEM_SH, MEM_SB:                   w_is_store = 1'b1;
            default: ;
        endcase
    end

    assign w_data_req = w_is_load | w_is_store;

    // Active-low lane enables for the pending store, from op and byte offset
    always_comb begin
        w_store_be_n = 4'b0000;
        case (bus.data_op_i)
            MEM_SH:  w_store_be_n = bus.data_bytes_i[1] ? 4'b0011 : 4'b1100;
            MEM_SB:  w_store_be_n = ~(4'b0001 << bus.data_bytes_i);
            default: w_store_be_n = 4'b0000;
        endcase
    end

    assign w_rd_done = (r_state == S_RD) && (r_cnt == RD_LAST);

    // Sequencer state and phase counter; the counter clears on every state entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_INST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_is_store) begin
                        r_state <= S_WR_SETUP;
                        r_owner <= OWN_DATA;
                    end else if (w_is_load) begin
                        r_state <= S_RD;
                        r_owner <= OWN_DATA;
                    end else if (bus.inst_req_i) begin
                        r_state <= S_RD;
                        r_owner <= OWN_INST;
                    end
                end
                S_RD: begin
                    if (w_rd_done) begin
                        r_state <= S_ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_PULSE;
                    r_cnt   <= '0;
                end
                S_WR_PULSE: begin
                    if (r_cnt == WR_LAST) begin
                        r_state <= S_WR_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    r_state <= S_ACK;
                    r_cnt   <= '0;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Latch address, store data and lane enables when IDLE grants an access,
    // so they stay stable for the whole SRAM cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be_n  <= 4'hF;
        end else if (r_state == S_IDLE) begin
            if (w_data_req) begin
                r_addr <= bus.data_addr_i;
                if (w_is_store) begin
                    r_wdata <= bus.data_wdata_i;
                    r_be_n  <= w_store_be_n;
                end
            end else if (bus.inst_req_i) begin
                r_addr <= bus.inst_addr_i;
            end
        end
    end

    // Capture SRAM read data into the owner's register on the last read cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else if (w_rd_done) begin
            if (r_owner == OWN_DATA) begin
                r_data_rdata <= sram_data_io;
            end else begin
                r_inst_rdata <= sram_data_io;
            end
        end
    end

    // Decode SRAM strobes, lane enables and bus drive from the current state;
    // decoding from state makes an asynchronous reset release them at once
    always_comb begin
        w_ce_n     = 1'b1;
        w_oe_n     = 1'b1;
        w_we_n     = 1'b1;
        w_be_n     = 4'hF;
        w_drive_en = 1'b0;
        case (r_state)
            S_RD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
                w_be_n = 4'b0000;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                w_ce_n     = 1'b0;
                w_be_n     = r_be_n;
                w_drive_en = 1'b1;
            end
            S_WR_PULSE: begin
                w_ce_n     = 1'b0;
                w_we_n     = 1'b0;
                w_be_n     = r_be_n;
                w_drive_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign sram_data_io    = w_drive_en ? r_wdata : 32'bz;

    assign bus.sram_addr_o = r_addr;
    assign bus.sram_ce_n_o = w_ce_n;
    assign bus.sram_oe_n_o = w_oe_n;
    assign bus.sram_we_n_o = w_we_n;
    assign bus.sram_be_n_o = w_be_n;

    assign bus.inst_rdata_o = r_inst_rdata;
    assign bus.data_rdata_o = r_data_rdata;

    // Stalls drop only in the owner's ACK cycle and are held low during reset
    assign bus.data_stall_o = rst & w_data_req &
                              ~((r_state == S_ACK) && (r_owner == OWN_DATA));
    assign bus.inst_stall_o = rst & bus.inst_req_i &
                              ~((r_state == S_ACK) && (r_owner == OWN_INST));

    assign bus.busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: one default-parameter instance
// and one instance with READ_CYCLES=3, each with a simple SRAM read model.
module tb_sram_port_arbiter;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd2;
    localparam logic [3:0] MEM_SW  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] sram_word;
    logic [31:0] sram_word3;
    wire  [31:0] sram_data;
    wire  [31:0] sram_data3;

    sram_port_arbiter_if bus_if ();
    sram_port_arbiter_if bus3_if ();

    sram_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .sram_data_io (sram_data)
    );

    sram_port_arbiter #(.READ_CYCLES(3), .WRITE_CYCLES(2)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus3_if),
        .sram_data_io (sram_data3)
    );

    // SRAM read models: drive the stored word while selected for a read
    assign sram_data  = (!bus_if.sram_ce_n_o && !bus_if.sram_oe_n_o && bus_if.sram_we_n_o)
                        ? sram_word : 32'bz;
    assign sram_data3 = (!bus3_if.sram_ce_n_o && !bus3_if.sram_oe_n_o && bus3_if.sram_we_n_o)
                        ? sram_word3 : 32'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the directed sequence is short, so this only fires on a hang
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        sram_word  = '0;
        sram_word3 = '0;
        rst = 1'b0;
        bus_if.inst_req_i   = 1'b1;
        bus_if.inst_addr_i  = 20'h00abc;
        bus_if.data_op_i    = MEM_SW;
        bus_if.data_addr_i  = 20'h00001;
        bus_if.data_bytes_i = 2'd0;
        bus_if.data_wdata_i = 32'h0;
        bus3_if.inst_req_i   = 1'b0;
        bus3_if.inst_addr_i  = '0;
        bus3_if.data_op_i    = MEM_NOP;
        bus3_if.data_addr_i  = '0;
        bus3_if.data_bytes_i = '0;
        bus3_if.data_wdata_i = '0;

        // Reset state, with requests pending to show the stalls are forced low
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   bus_if.busy_o, 0);
        chk("rst_ce",     bus_if.sram_ce_n_o, 1);
        chk("rst_oe",     bus_if.sram_oe_n_o, 1);
        chk("rst_we",     bus_if.sram_we_n_o, 1);
        chk("rst_be",     bus_if.sram_be_n_o, 4'hF);
        chk("rst_addr",   bus_if.sram_addr_o, 0);
        chk("rst_irdata", bus_if.inst_rdata_o, 0);
        chk("rst_drdata", bus_if.data_rdata_o, 0);
        chk("rst_istall", bus_if.inst_stall_o, 0);
        chk("rst_dstall", bus_if.data_stall_o, 0);
        chk("rst_drive",  dut.w_drive_en, 0);
        bus_if.inst_req_i = 1'b0;
        bus_if.data_op_i  = MEM_NOP;
        rst = 1'b1;

        // Fetch only, addr 0x10
        tick();
        sram_word = 32'h3C08BFD0;
        bus_if.inst_addr_i = 20'h00010;
        bus_if.inst_req_i  = 1'b1;
        #1;
        chk("A1_stall", bus_if.inst_stall_o, 1);
        chk("A1_busy",  bus_if.busy_o, 0);
        chk("A1_ce",    bus_if.sram_ce_n_o, 1);
        tick();
        chk("A2_stall", bus_if.inst_stall_o, 1);
        chk("A2_ce",    bus_if.sram_ce_n_o, 0);
        chk("A2_oe",    bus_if.sram_oe_n_o, 0);
        chk("A2_we",    bus_if.sram_we_n_o, 1);
        chk("A2_be",    bus_if.sram_be_n_o, 4'b0000);
        chk("A2_addr",  bus_if.sram_addr_o, 20'h00010);
        chk("A2_busy",  bus_if.busy_o, 1);
        tick();
        chk("A3_stall", bus_if.inst_stall_o, 0);
        chk("A3_rdata", bus_if.inst_rdata_o, 32'h3C08BFD0);
        chk("A3_ce",    bus_if.sram_ce_n_o, 1);
        chk("A3_oe",    bus_if.sram_oe_n_o, 1);
        chk("A3_busy",  bus_if.busy_o, 1);
        tick();
        bus_if.inst_req_i = 1'b0;
        #1;
        chk("A4_busy",  bus_if.busy_o, 0);
        chk("A4_rdata", bus_if.inst_rdata_o, 32'h3C08BFD0);

        // Simultaneous fetch and SW: write first, then the fetch
        tick();
        sram_word = 32'h12345678;
        bus_if.inst_req_i   = 1'b1;
        bus_if.inst_addr_i  = 20'h00004;
        bus_if.data_op_i    = MEM_SW;
        bus_if.data_addr_i  = 20'h00100;
        bus_if.data_bytes_i = 2'd0;
        bus_if.data_wdata_i = 32'hDEADBEEF;
        #1;
        chk("B1_dstall", bus_if.data_stall_o, 1);
        chk("B1_istall", bus_if.inst_stall_o, 1);
        tick();
        chk("B2_ce",     bus_if.sram_ce_n_o, 0);
        chk("B2_oe",     bus_if.sram_oe_n_o, 1);
        chk("B2_we",     bus_if.sram_we_n_o, 1);
        chk("B2_be",     bus_if.sram_be_n_o, 4'b0000);
        chk("B2_addr",   bus_if.sram_addr_o, 20'h00100);
        chk("B2_bus",    sram_data, 32'hDEADBEEF);
        chk("B2_dstall", bus_if.data_stall_o, 1);
        tick();
        chk("B3_we",     bus_if.sram_we_n_o, 0);
        chk("B3_bus",    sram_data, 32'hDEADBEEF);
        tick();
        chk("B4_we",     bus_if.sram_we_n_o, 0);
        chk("B4_istall", bus_if.inst_stall_o, 1);
        tick();
        chk("B5_we",     bus_if.sram_we_n_o, 1);
        chk("B5_ce",     bus_if.sram_ce_n_o, 0);
        chk("B5_bus",    sram_data, 32'hDEADBEEF);
        chk("B5_dstall", bus_if.data_stall_o, 1);
        tick();
        chk("B6_dstall", bus_if.data_stall_o, 0);
        chk("B6_istall", bus_if.inst_stall_o, 1);
        chk("B6_ce",     bus_if.sram_ce_n_o, 1);
        chk("B6_drive",  dut.w_drive_en, 0);
        tick();
        bus_if.data_op_i = MEM_NOP;
        #1;
        chk("B7_istall", bus_if.inst_stall_o, 1);
        chk("B7_busy",   bus_if.busy_o, 0);
        tick();
        chk("B8_addr",   bus_if.sram_addr_o, 20'h00004);
        chk("B8_oe",     bus_if.sram_oe_n_o, 0);
        chk("B8_istall", bus_if.inst_stall_o, 1);
        tick();
        chk("B9_istall", bus_if.inst_stall_o, 0);
        chk("B9_rdata",  bus_if.inst_rdata_o, 32'h12345678);
        tick();
        bus_if.inst_req_i = 1'b0;
        #1;
        chk("B10_busy",  bus_if.busy_o, 0);

        // SB offset 3, then SH offset 2
        tick();
        bus_if.data_op_i    = MEM_SB;
        bus_if.data_addr_i  = 20'h00300;
        bus_if.data_bytes_i = 2'd3;
        bus_if.data_wdata_i = 32'hAB000000;
        #1;
        tick();
        chk("C2_be",     bus_if.sram_be_n_o, 4'b0111);
        tick();
        chk("C3_be",     bus_if.sram_be_n_o, 4'b0111);
        chk("C3_we",     bus_if.sram_we_n_o, 0);
        tick();
        chk("C4_be",     bus_if.sram_be_n_o, 4'b0111);
        tick();
        chk("C5_be",     bus_if.sram_be_n_o, 4'b0111);
        chk("C5_bus",    sram_data, 32'hAB000000);
        tick();
        chk("C6_be",     bus_if.sram_be_n_o, 4'hF);
        chk("C6_dstall", bus_if.data_stall_o, 0);
        tick();
        bus_if.data_op_i    = MEM_SH;
        bus_if.data_bytes_i = 2'd2;
        bus_if.data_wdata_i = 32'hBEEF0000;
        #1;
        chk("C7_dstall", bus_if.data_stall_o, 1);
        tick();
        chk("C8_be",     bus_if.sram_be_n_o, 4'b0011);
        tick();
        tick();
        tick();
        chk("C11_be",    bus_if.sram_be_n_o, 4'b0011);
        tick();
        chk("C12_dstall", bus_if.data_stall_o, 0);
        tick();
        bus_if.data_op_i = MEM_NOP;
        #1;

        // LB on the READ_CYCLES=3 instance; NOP and undefined op on the default one
        tick();
        sram_word3 = 32'h11223344;
        bus3_if.data_op_i   = MEM_LB;
        bus3_if.data_addr_i = 20'h00200;
        bus_if.data_op_i    = MEM_NOP;
        bus_if.data_addr_i  = 20'h00077;
        #1;
        chk("D1_stall",  bus3_if.data_stall_o, 1);
        chk("D1_nop_stall", bus_if.data_stall_o, 0);
        tick();
        chk("D2_stall",  bus3_if.data_stall_o, 1);
        chk("D2_oe",     bus3_if.sram_oe_n_o, 0);
        chk("D2_addr",   bus3_if.sram_addr_o, 20'h00200);
        chk("D2_nop_ce", bus_if.sram_ce_n_o, 1);
        chk("D2_nop_busy", bus_if.busy_o, 0);
        bus_if.data_op_i = 4'hF;
        #1;
        chk("D2_undef_stall", bus_if.data_stall_o, 0);
        tick();
        chk("D3_stall",  bus3_if.data_stall_o, 1);
        chk("D3_undef_ce", bus_if.sram_ce_n_o, 1);
        tick();
        chk("D4_stall",  bus3_if.data_stall_o, 1);
        chk("D4_oe",     bus3_if.sram_oe_n_o, 0);
        tick();
        chk("D5_stall",  bus3_if.data_stall_o, 0);
        chk("D5_rdata",  bus3_if.data_rdata_o, 32'h11223344);
        chk("D5_oe",     bus3_if.sram_oe_n_o, 1);
        tick();
        bus3_if.data_op_i = MEM_NOP;
        bus_if.data_op_i  = MEM_NOP;
        #1;

        // Back-to-back fetches of words 0, 1, 2
        for (int k = 0; k < 3; k++) begin
            tick();
            sram_word = 32'hA0 + k;
            bus_if.inst_addr_i = 20'(k);
            bus_if.inst_req_i  = 1'b1;
            #1;
            chk("E_idle_busy",  bus_if.busy_o, 0);
            chk("E_idle_stall", bus_if.inst_stall_o, 1);
            tick();
            chk("E_rd_busy",    bus_if.busy_o, 1);
            chk("E_rd_addr",    bus_if.sram_addr_o, 20'(k));
            tick();
            chk("E_ack_stall",  bus_if.inst_stall_o, 0);
            chk("E_ack_busy",   bus_if.busy_o, 1);
            chk("E_ack_rdata",  bus_if.inst_rdata_o, 32'hA0 + k);
        end
        tick();
        bus_if.inst_req_i = 1'b0;
        #1;

        // Asynchronous reset in the middle of a write pulse
        tick();
        bus_if.data_op_i    = MEM_SW;
        bus_if.data_addr_i  = 20'h00055;
        bus_if.data_wdata_i = 32'h01020304;
        #1;
        tick();
        tick();
        chk("F_pulse_we", bus_if.sram_we_n_o, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("F_rst_we",    bus_if.sram_we_n_o, 1);
        chk("F_rst_ce",    bus_if.sram_ce_n_o, 1);
        chk("F_rst_drive", dut.w_drive_en, 0);
        chk("F_rst_busy",  bus_if.busy_o, 0);
        chk("F_rst_dstall", bus_if.data_stall_o, 0);
        bus_if.data_op_i = MEM_NOP;
        tick();
        rst = 1'b1;
        tick();
        chk("F_rel_busy",   bus_if.busy_o, 0);
        chk("F_rel_istall", bus_if.inst_stall_o, 0);
        chk("F_rel_dstall", bus_if.data_stall_o, 0);
        chk("F_rel_addr",   bus_if.sram_addr_o, 0);
        chk("F_rel_irdata", bus_if.inst_rdata_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single external word-addressed SRAM and shares it between the instruction-fetch port and the data port.
- Both ports arrive already translated: 20-bit word addresses from the address-translation stage.
- Data accesses have strict priority over fetch.
- The block generates SRAM strobes, byte enables and tri-state control, and stalls each requester until its access completes.

Parameters:
READ_CYCLES, 1, cycles address/oe_n held before read data is sampled (min 1)
WRITE_CYCLES, 2, cycles sram_we_n_o held low per write (min 1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
inst_req_i  in  1  fetch request, held stable while inst_stall_o=1
inst_addr_i  in  20  fetch word address
inst_rdata_o  out  32  fetched word, valid in ACK cycle and held until next fetch capture
inst_stall_o  out  1  fetch not yet complete
data_op_i  in  4  MEM_* op code; held stable while data_stall_o=1
data_addr_i  in  20  data word address
data_bytes_i  in  2  byte offset within word
data_wdata_i  in  32  store data, already lane-aligned
data_rdata_o  out  32  loaded word (raw, extension done downstream), valid in ACK, held until next load capture
data_stall_o  out  1  data access not yet complete
sram_addr_o  out  20  SRAM word address
sram_data_io  inout  32  SRAM data bus
sram_ce_n_o  out  1  chip enable, active low
sram_oe_n_o  out  1  output enable, active low
sram_we_n_o  out  1  write enable, active low
sram_be_n_o  out  4  byte enables, active low
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters 0, sram_addr_o=0.
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o =1; sram_be_n_o=4'hF; sram_data_io high-Z.
  - inst_rdata_o=0, data_rdata_o=0; both stalls forced 0; busy_o=0.
  - Reset mid-write deasserts sram_we_n_o immediately.
- Op classes:
  - load = MEM_LW/LB/LBU/LH/LHU; store = MEM_SW/SH/SB.
  - Any other op (incl. MEM_NOP) is no request: data_stall_o=0 and no SRAM activity.
- Stalls (combinational):
  - data_stall_o = data request pending & not (state==ACK & owner==DATA).
  - inst_stall_o = inst_req_i & not (state==ACK & owner==INST).
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE (one cycle, registers owner):
  - store pending -> WR_SETUP, owner=DATA.
  - else load pending -> RD, owner=DATA.
  - else inst_req_i -> RD, owner=INST.
  - else stay. Data always wins a simultaneous request.
- RD:
  - Drives addr of owner; ce_n=0, oe_n=0, we_n=1, be_n=0000.
  - Counts READ_CYCLES cycles; on the last cycle captures sram_data_io into owner's rdata register, then -> ACK.
- WR_SETUP (1 cycle):
  - ce_n=0, oe_n=1, we_n=1; addr, be_n and data driven.
- WR_PULSE (WRITE_CYCLES cycles): as WR_SETUP with we_n=0.
- WR_HOLD (1 cycle):
  - we_n=1, data still driven, then -> ACK.
  - Addr, data and be_n are stable across the whole SETUP..HOLD window.
- ACK (1 cycle):
  - SRAM idle (all strobes high, bus high-Z); owner's stall low.
  - Pipeline advances on this edge; -> IDLE.
  - A request unchanged after ACK is treated as new; requesters must not re-present the same access.
- Latency:
  - Read stall = READ_CYCLES+1 cycles (default 2); ACK in cycle 3 after the request appears.
  - Write stall = WRITE_CYCLES+3 (default 5).
- A fetch pending during a data access stays stalled and is served after the data ACK, with no extra IDLE bubble beyond the normal IDLE cycle.
- Byte enables for stores:
  - SW -> 0000.
  - SH -> data_bytes_i[1]=0 ? 1100 : 0011.
  - SB -> only lane data_bytes_i low (e.g. offset 2 -> 1011).
- sram_data_io is driven only in WR_* states; it is high-Z in every other state.
- Counters are sized to clog2(max param)+1 and clear on every state entry.

Test Plan:
- Reset with rst=0 mid-WR_PULSE -> sram_we_n_o=1 and bus high-Z the same cycle; after release state=IDLE, stalls 0.
- Fetch only, addr 20'h00010, SRAM returns 32'h3C08BFD0 -> inst_stall_o high 2 cycles, low in cycle 3 with inst_rdata_o=32'h3C08BFD0; strobes ce_n/oe_n low exactly 1 cycle.
- Simultaneous fetch addr 20'h00004 and MEM_SW addr 20'h00100 data 32'hDEADBEEF -> write first:
  - we_n low 2 cycles, be_n=0000, data_stall_o low in cycle 6.
  - Fetch then completes 3 cycles later; inst_stall_o high throughout until then.
- MEM_SB offset 3 data 32'hAB000000 -> be_n=0111 over SETUP..HOLD; MEM_SH offset 2 -> be_n=0011.
- MEM_LB addr 20'h00200 with SRAM word 32'h11223344, READ_CYCLES=3 -> data_stall_o high 4 cycles, data_rdata_o=32'h11223344 in ACK; MEM_NOP -> no strobes, stall 0.
- Back-to-back fetches 20'h0, 20'h1, 20'h2 -> three ACKs spaced 3 cycles apart; busy_o low only in each IDLE cycle.
